// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and helpers shared by the decode/execute pipeline.
//   NOP_INST       instruction placed in the inst field of a bubble
//   F_*            field indices inside the packed decode bus
//   pipe_state_t   occupancy encoding {skid_valid, main_valid}
//   bubble_pattern packed bus with every field zero except the inst field
package pipe_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int F_ADDR  = 0;
    localparam int F_IMMED = 1;
    localparam int F_INST  = 2;
    localparam int F_RD1   = 3;
    localparam int F_RD2   = 4;

    // Upper bound on packed bus width handled by bubble_pattern; callers
    // truncate the result to their own bus width.
    localparam int MAX_BUS = 2048;

    // Encoded as {skid_valid, main_valid}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } pipe_state_t;

    function automatic logic [MAX_BUS-1:0] bubble_pattern(
        input int          dwidth,
        input int          nfields,
        input int          inst_idx,
        input logic [31:0] nop
    );
        logic [MAX_BUS-1:0] field_mask;
        logic [MAX_BUS-1:0] bus_mask;
        logic [MAX_BUS-1:0] field;
        field_mask = (MAX_BUS'(1) << dwidth) - MAX_BUS'(1);
        bus_mask   = (MAX_BUS'(1) << (dwidth * nfields)) - MAX_BUS'(1);
        field      = MAX_BUS'(nop) & field_mask;
        return (field << (inst_idx * dwidth)) & bus_mask;
    endfunction

endpackage

// File: rtl/decode_pipe_reg.sv
// decode_pipe_reg: decode-to-execute pipeline register with a valid/ready
// handshake, a two-entry skid buffer, flush-to-bubble and a saturating
// stall-cycle counter.
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_ready = !skid_valid
//   in_data               NFIELDS packed DWIDTH-bit fields
//   flush                 synchronous kill of all held entries, main <= bubble
//   out_valid/out_ready   downstream handshake
//   out_data              main entry contents
//   stall_cnt, clr_cnt    saturating count of out_valid && !out_ready cycles
// All outputs come straight from registers.
module decode_pipe_reg #(
    parameter int          DWIDTH   = 32,
    parameter int          NFIELDS  = 5,
    parameter int          INST_IDX = 2,
    parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST,
    parameter int          CNTW     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NFIELDS*DWIDTH-1:0] in_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NFIELDS*DWIDTH-1:0] out_data,
    output logic [CNTW-1:0]           stall_cnt,
    input  logic                      clr_cnt
);
    import pipe_pkg::*;

    localparam int              W       = NFIELDS * DWIDTH;
    localparam logic [W-1:0]    BUBBLE  = W'(bubble_pattern(DWIDTH, NFIELDS, INST_IDX, NOP_INST));
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic            r_main_valid;
    logic            r_skid_valid;
    logic [W-1:0]    r_main_data;
    logic [W-1:0]    r_skid_data;
    logic [CNTW-1:0] r_stall_cnt;

    logic        w_push;
    logic        w_pop;
    pipe_state_t w_state;

    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

    assign w_push  = in_valid && !r_skid_valid;
    assign w_pop   = r_main_valid && out_ready;
    assign w_state = pipe_state_t'({r_skid_valid, r_main_valid});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= BUBBLE;
            r_skid_data  <= '0;
        end else if (flush) begin
            // A concurrent pop has already been sampled downstream; a
            // concurrent push is simply dropped.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= BUBBLE;
        end else begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_main_valid <= 1'b1;
                        r_main_data  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_main_data <= in_data;
                    end else if (w_push) begin
                        // Consumer stalled: park the extra beat behind main.
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= in_data;
                    end else if (w_pop) begin
                        // main_data is left as-is; out_valid qualifies it.
                        r_main_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_skid_valid <= 1'b0;
                        r_main_data  <= r_skid_data;
                    end
                end
                default: begin
                    // Unreachable {skid, !main}: recover to empty.
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end
            endcase
        end
    end

    // Stall counter is independent of flush; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
        end else if (r_main_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_pipe_reg.sv
module tb_decode_pipe_reg;

    localparam int DW = 32;
    localparam int NF = 5;
    localparam int W  = DW * NF;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;
    logic          clr_cnt = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_pipe_reg #(
        .DWIDTH(DW), .NFIELDS(NF), .INST_IDX(2), .NOP_INST(32'h0000_0013), .CNTW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
    );

    // Bubble: only the inst field (index 2, bits 95:64) holds 0x13.
    logic [W-1:0] bubble;
    initial bubble = W'(32'h0000_0013) << 64;

    // Full packed beat derived from addr and inst so every field is exercised.
    function automatic logic [W-1:0] mk(input logic [31:0] addr, input logic [31:0] inst);
        return {inst + 32'h1, addr ^ inst, inst, ~addr, addr};
    endfunction

    typedef struct {
        logic          iv;
        logic [31:0]   addr;
        logic [31:0]   inst;
        logic          ordy;
        logic          fl;
        logic          clr;
        logic          ev;
        logic          erdy;
        logic [W-1:0]  edata;
        logic [CW-1:0] ecnt;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic iv, input logic [31:0] addr, input logic [31:0] inst,
                        input logic ordy, input logic fl, input logic clr,
                        input logic ev, input logic erdy, input logic [W-1:0] edata,
                        input logic [CW-1:0] ecnt);
        vec_t v;
        v.iv = iv; v.addr = addr; v.inst = inst; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.ev = ev; v.erdy = erdy; v.edata = edata; v.ecnt = ecnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl; clr_cnt = clr;
    endtask

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] rd;
        logic         push, pop;
        int           n;

        // Stimulus table: streaming, skid fill/drain, clear, flush cases.
        for (int k = 0; k < 10; k++)
            addv(1, 32'h100 + 32'(4*k), 32'h00A0_0093 + 32'(k) * 32'h0010_0000, 1, 0, 0,
                 1, 1, mk(32'h100 + 32'(4*k), 32'h00A0_0093 + 32'(k) * 32'h0010_0000), 0);
        addv(0, 0, 0, 1, 0, 0, 0, 1, mk(32'h124, 32'h00A0_0093 + 32'd9 * 32'h0010_0000), 0);
        addv(1, 32'h200, 32'h11, 0, 0, 0, 1, 1, mk(32'h200, 32'h11), 0);
        addv(1, 32'h204, 32'h22, 0, 0, 0, 1, 0, mk(32'h200, 32'h11), 1);
        addv(1, 32'h208, 32'h99, 0, 0, 0, 1, 0, mk(32'h200, 32'h11), 2);
        addv(0, 0, 0, 1, 0, 0, 1, 1, mk(32'h204, 32'h22), 2);
        addv(0, 0, 0, 1, 0, 0, 0, 1, mk(32'h204, 32'h22), 2);
        addv(0, 0, 0, 1, 0, 1, 0, 1, mk(32'h204, 32'h22), 0);
        addv(1, 32'h300, 32'h33, 0, 0, 0, 1, 1, mk(32'h300, 32'h33), 0);
        addv(1, 32'h304, 32'h34, 0, 0, 0, 1, 0, mk(32'h300, 32'h33), 1);
        addv(1, 32'h308, 32'h44, 0, 1, 0, 0, 1, bubble, 2);
        addv(0, 0, 0, 1, 0, 0, 0, 1, bubble, 2);
        addv(1, 32'h400, 32'h55, 1, 0, 0, 1, 1, mk(32'h400, 32'h55), 2);
        addv(0, 0, 0, 1, 1, 0, 0, 1, bubble, 2);

        // Asynchronous reset, checked without a clock edge.
        #1 rst = 1'b1;
        #1;
        chk("reset out_valid", W'(out_valid), W'(0));
        chk("reset in_ready", W'(in_ready), W'(1));
        chk("reset out_data", out_data, bubble);
        chk("reset stall_cnt", W'(stall_cnt), W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].iv, mk(vq[i].addr, vq[i].inst), vq[i].ordy, vq[i].fl, vq[i].clr);
            step();
            chk($sformatf("vec%0d out_valid", i), W'(out_valid), W'(vq[i].ev));
            chk($sformatf("vec%0d in_ready", i), W'(in_ready), W'(vq[i].erdy));
            chk($sformatf("vec%0d out_data", i), out_data, vq[i].edata);
            chk($sformatf("vec%0d stall_cnt", i), W'(stall_cnt), W'(vq[i].ecnt));
            $display("vec %0d: out_valid=%0b in_ready=%0b inst=%h cnt=%0d",
                     i, out_valid, in_ready, out_data[64 +: 32], stall_cnt);
        end

        // Stall counter saturation, then clear coincident with a stall cycle.
        drive(1, mk(32'h500, 32'h66), 0, 0, 1);
        step();
        chk("sat start cnt", W'(stall_cnt), W'(0));
        drive(0, '0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("sat cyc%0d cnt", i), W'(stall_cnt), W'((i < 15) ? i : 15));
        end
        $display("saturation: stall_cnt=%0d", stall_cnt);
        clr_cnt = 1'b1;
        step();
        chk("clr during stall", W'(stall_cnt), W'(0));
        clr_cnt = 1'b0;
        step();
        chk("count after clr", W'(stall_cnt), W'(1));
        chk("held beat", out_data, mk(32'h500, 32'h66));
        out_ready = 1'b1;
        step();
        chk("sat drain valid", W'(out_valid), W'(0));

        // Random valid/ready against a FIFO scoreboard.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)), 0, 0);
            push = in_valid && in_ready;
            pop  = out_valid && out_ready;
            if (pop) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand dup: pop at cycle %0d with empty scoreboard", cyc);
                end else begin
                    chk($sformatf("rand cyc%0d data", cyc), out_data, q.pop_front());
                end
            end
            if (push) q.push_back(rd);
            step();
        end
        drive(0, '0, 1, 0, 0);
        n = 0;
        while (q.size() > 0 && n < 10) begin
            if (out_valid) chk($sformatf("drain%0d data", n), out_data, q.pop_front());
            step();
            n++;
        end
        chk("rand leftover", W'(q.size()), W'(0));
        chk("rand final valid", W'(out_valid), W'(0));
        $display("random: %0d checks so far, %0d errors", checks, errors);

        // Asynchronous reset while FULL.
        drive(1, mk(32'h600, 32'h77), 0, 0, 0);
        step();
        drive(1, mk(32'h604, 32'h78), 0, 0, 0);
        step();
        chk("pre-rst in_ready", W'(in_ready), W'(0));
        drive(0, '0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst out_valid", W'(out_valid), W'(0));
        chk("midrst in_ready", W'(in_ready), W'(1));
        chk("midrst out_data", out_data, bubble);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post-rst out_valid", W'(out_valid), W'(0));
        $display("mid-op reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
